// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 matrix keypad: ASCII key codes, the
// active-low row/column line patterns and the emulator state encoding.
// The keypad scanner imports the same package so both ends agree on the map.
package keypad_pkg;

    // ASCII codes of the sixteen keys on the pad
    localparam logic [7:0] KEY_0    = 8'h30;
    localparam logic [7:0] KEY_1    = 8'h31;
    localparam logic [7:0] KEY_2    = 8'h32;
    localparam logic [7:0] KEY_3    = 8'h33;
    localparam logic [7:0] KEY_4    = 8'h34;
    localparam logic [7:0] KEY_5    = 8'h35;
    localparam logic [7:0] KEY_6    = 8'h36;
    localparam logic [7:0] KEY_7    = 8'h37;
    localparam logic [7:0] KEY_8    = 8'h38;
    localparam logic [7:0] KEY_9    = 8'h39;
    localparam logic [7:0] KEY_A    = 8'h41;
    localparam logic [7:0] KEY_B    = 8'h42;
    localparam logic [7:0] KEY_C    = 8'h43;
    localparam logic [7:0] KEY_D    = 8'h44;
    localparam logic [7:0] KEY_STAR = 8'h2A;
    localparam logic [7:0] KEY_HASH = 8'h23;

    // Active-low line pattern for index 0..3: index i drives bit (3-i) low
    localparam logic [3:0] ROW_PATTERN [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
    localparam logic [3:0] COL_PATTERN [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

    // Emulator press sequence
    typedef enum logic [2:0] {
        IDLE,
        BOUNCE_IN,
        HOLD,
        BOUNCE_OUT,
        GAP
    } keypad_state_e;

    // Largest of four timing parameters, used to size the shared counters
    function automatic int unsigned maxOf4(input int unsigned a, input int unsigned b,
                                           input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/keypad_ascii_decode.sv
// Combinational ASCII-to-keypad-position decoder. Anything outside the
// sixteen printed keys (including lowercase letters) reports mapped_o = 0.
module keypad_ascii_decode
    import keypad_pkg::*;
(
    input  logic [7:0] key_char_i,
    output logic       mapped_o,
    output logic [1:0] row_idx_o,
    output logic [1:0] col_idx_o
);

    // Look up the row/column of the requested key
    always_comb begin
        mapped_o  = 1'b1;
        row_idx_o = 2'd0;
        col_idx_o = 2'd0;
        case (key_char_i)
            KEY_1:    begin row_idx_o = 2'd0; col_idx_o = 2'd0; end
            KEY_2:    begin row_idx_o = 2'd0; col_idx_o = 2'd1; end
            KEY_3:    begin row_idx_o = 2'd0; col_idx_o = 2'd2; end
            KEY_A:    begin row_idx_o = 2'd0; col_idx_o = 2'd3; end
            KEY_4:    begin row_idx_o = 2'd1; col_idx_o = 2'd0; end
            KEY_5:    begin row_idx_o = 2'd1; col_idx_o = 2'd1; end
            KEY_6:    begin row_idx_o = 2'd1; col_idx_o = 2'd2; end
            KEY_B:    begin row_idx_o = 2'd1; col_idx_o = 2'd3; end
            KEY_7:    begin row_idx_o = 2'd2; col_idx_o = 2'd0; end
            KEY_8:    begin row_idx_o = 2'd2; col_idx_o = 2'd1; end
            KEY_9:    begin row_idx_o = 2'd2; col_idx_o = 2'd2; end
            KEY_C:    begin row_idx_o = 2'd2; col_idx_o = 2'd3; end
            KEY_STAR: begin row_idx_o = 2'd3; col_idx_o = 2'd0; end
            KEY_0:    begin row_idx_o = 2'd3; col_idx_o = 2'd1; end
            KEY_HASH: begin row_idx_o = 2'd3; col_idx_o = 2'd2; end
            KEY_D:    begin row_idx_o = 2'd3; col_idx_o = 2'd3; end
            default:  mapped_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/keypad_emulador.sv
// Keypad responder: accepts one ASCII key over valid/ready and then acts as a
// physical 4x4 pad, pulling the key's column low while the scanner drives its
// row low. Press and release can be wrapped in a contact-bounce window.
module keypad_emulador
    import keypad_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES   = 2000000,
    parameter int unsigned GAP_CYCLES    = 1500000,
    parameter int unsigned BOUNCE_CYCLES = 50000,
    parameter int unsigned BOUNCE_PERIOD = 5000
)(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] key_char,
    input  logic       key_valid,
    output logic       key_ready,
    input  logic [3:0] row,
    output logic [3:0] column,
    output logic       busy,
    output logic       done,
    output logic       key_error
);

    localparam int unsigned CNT_W = $clog2(maxOf4(HOLD_CYCLES, GAP_CYCLES,
                                                  BOUNCE_CYCLES, BOUNCE_PERIOD) + 1);
    localparam bit         BOUNCE_EN    = (BOUNCE_CYCLES != 0);
    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] BOUNCE_LAST  = CNT_W'(BOUNCE_EN ? BOUNCE_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] PERIOD_LAST  = CNT_W'(BOUNCE_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    keypad_state_e    state_q;
    logic [CNT_W-1:0] cycleCnt_q;
    logic [CNT_W-1:0] phaseCnt_q;
    logic             contact_q;
    logic [1:0]       keyRow_q;
    logic [1:0]       keyCol_q;
    logic             keyReady_q;
    logic             busy_q;
    logic             done_q;
    logic             keyError_q;
    logic [3:0]       column_q;
    logic [3:0]       column_d;

    logic             decMapped;
    logic [1:0]       decRow;
    logic [1:0]       decCol;

    keypad_ascii_decode u_decode (
        .key_char_i (key_char),
        .mapped_o   (decMapped),
        .row_idx_o  (decRow),
        .col_idx_o  (decCol)
    );

    // Press sequence: timing counters, simulated contact and handshake outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cycleCnt_q <= '0;
            phaseCnt_q <= '0;
            contact_q  <= 1'b0;
            keyRow_q   <= 2'd0;
            keyCol_q   <= 2'd0;
            keyReady_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            keyError_q <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            keyError_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (key_valid && keyReady_q) begin
                        if (decMapped) begin
                            keyRow_q   <= decRow;
                            keyCol_q   <= decCol;
                            cycleCnt_q <= '0;
                            phaseCnt_q <= '0;
                            contact_q  <= 1'b1;
                            keyReady_q <= 1'b0;
                            busy_q     <= 1'b1;
                            state_q    <= BOUNCE_EN ? BOUNCE_IN : HOLD;
                        end else begin
                            keyError_q <= 1'b1;
                        end
                    end
                end
                BOUNCE_IN: begin
                    if (cycleCnt_q == BOUNCE_LAST) begin
                        cycleCnt_q <= '0;
                        contact_q  <= 1'b1;
                        state_q    <= HOLD;
                    end else begin
                        cycleCnt_q <= cycleCnt_q + CNT_ONE;
                        if (phaseCnt_q == PERIOD_LAST) begin
                            phaseCnt_q <= '0;
                            contact_q  <= ~contact_q;
                        end else begin
                            phaseCnt_q <= phaseCnt_q + CNT_ONE;
                        end
                    end
                end
                HOLD: begin
                    if (cycleCnt_q == HOLD_LAST) begin
                        cycleCnt_q <= '0;
                        phaseCnt_q <= '0;
                        contact_q  <= 1'b0;
                        state_q    <= BOUNCE_EN ? BOUNCE_OUT : GAP;
                    end else begin
                        cycleCnt_q <= cycleCnt_q + CNT_ONE;
                    end
                end
                BOUNCE_OUT: begin
                    if (cycleCnt_q == BOUNCE_LAST) begin
                        cycleCnt_q <= '0;
                        contact_q  <= 1'b0;
                        state_q    <= GAP;
                    end else begin
                        cycleCnt_q <= cycleCnt_q + CNT_ONE;
                        if (phaseCnt_q == PERIOD_LAST) begin
                            phaseCnt_q <= '0;
                            contact_q  <= ~contact_q;
                        end else begin
                            phaseCnt_q <= phaseCnt_q + CNT_ONE;
                        end
                    end
                end
                GAP: begin
                    if (cycleCnt_q == GAP_LAST) begin
                        cycleCnt_q <= '0;
                        contact_q  <= 1'b0;
                        keyReady_q <= 1'b1;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        state_q    <= IDLE;
                    end else begin
                        cycleCnt_q <= cycleCnt_q + CNT_ONE;
                    end
                end
                default: begin
                    cycleCnt_q <= '0;
                    contact_q  <= 1'b0;
                    keyReady_q <= 1'b1;
                    busy_q     <= 1'b0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    // Close the switch only when the latched key's row is being driven low
    always_comb begin
        column_d = 4'b1111;
        if (contact_q && ((row | ROW_PATTERN[keyRow_q]) == ROW_PATTERN[keyRow_q])) begin
            column_d = COL_PATTERN[keyCol_q];
        end
    end

    // Column lines are registered so the scanner sees one cycle of latency
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            column_q <= 4'b1111;
        end else begin
            column_q <= column_d;
        end
    end

    assign key_ready = keyReady_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign key_error = keyError_q;
    assign column    = column_q;

endmodule

// File: tb/tb_keypad_emulador.sv
// Scoreboard bench for keypad_emulador. Two instances share the stimulus:
// one without bounce and one with an 8-cycle bounce window toggling every
// 2 cycles. A timeline model predicts every output cycle by cycle.
module tb_keypad_emulador;

    localparam int unsigned HOLD = 20;
    localparam int unsigned GAP  = 10;
    localparam int unsigned B0   = 0;
    localparam int unsigned P0   = 1;
    localparam int unsigned B1   = 8;
    localparam int unsigned P1   = 2;

    typedef struct packed {
        logic [3:0] column;
        logic       ready;
        logic       busy;
        logic       done;
        logic       err;
    } exp_t;

    typedef struct packed {
        exp_t e0;
        exp_t e1;
    } exp_pair_t;

    localparam exp_t RESET_EXP = '{column: 4'b1111, ready: 1'b1, busy: 1'b0,
                                   done: 1'b0, err: 1'b0};

    logic       clk;
    logic       rst;
    logic [7:0] keyChar;
    logic       keyValid;
    logic [3:0] rowIn;

    logic [3:0] column0, column1;
    logic       ready0, ready1, busy0, busy1, done0, done1, err0, err1;

    exp_pair_t  expQ[$];
    int         compared;
    int         mismatched;
    int         cycleNum;

    bit         mActive  [2];
    int         mK       [2];
    int         mRow     [2];
    int         mCol     [2];
    bit         mContact [2];

    keypad_emulador #(
        .HOLD_CYCLES   (HOLD),
        .GAP_CYCLES    (GAP),
        .BOUNCE_CYCLES (B0),
        .BOUNCE_PERIOD (P0)
    ) dutNoBounce (
        .clk       (clk),
        .rst       (rst),
        .key_char  (keyChar),
        .key_valid (keyValid),
        .key_ready (ready0),
        .row       (rowIn),
        .column    (column0),
        .busy      (busy0),
        .done      (done0),
        .key_error (err0)
    );

    keypad_emulador #(
        .HOLD_CYCLES   (HOLD),
        .GAP_CYCLES    (GAP),
        .BOUNCE_CYCLES (B1),
        .BOUNCE_PERIOD (P1)
    ) dutBounce (
        .clk       (clk),
        .rst       (rst),
        .key_char  (keyChar),
        .key_valid (keyValid),
        .key_ready (ready1),
        .row       (rowIn),
        .column    (column1),
        .busy      (busy1),
        .done      (done1),
        .key_error (err1)
    );

    // Free-running clock, 10 time units per cycle
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Position 0..15 of a char on the printed pad, or -1 if it is not a key
    function automatic int keyIndex(input logic [7:0] ch);
        string keyMap;
        keyMap = "123A456B789C*0#D";
        for (int i = 0; i < 16; i++) begin
            if (keyMap[i] == ch) return i;
        end
        return -1;
    endfunction

    // Contact state k cycles after acceptance, from the press timeline
    function automatic bit contactAt(input int k, input int b, input int p);
        if (k < b)               return ((k / p) % 2) == 0;
        else if (k < b + HOLD)   return 1'b1;
        else if (k < 2*b + HOLD) return (((k - b - HOLD) / p) % 2) == 1;
        else                     return 1'b0;
    endfunction

    function automatic logic [3:0] colBits(input int c);
        logic [3:0] pat;
        pat = 4'b1111;
        pat[3 - c] = 1'b0;
        return pat;
    endfunction

    // Reference model: one expectation per clock edge for both instances
    initial begin : model
        exp_t      e;
        exp_pair_t p;
        int        idx;
        int        b;
        int        per;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                for (int i = 0; i < 2; i++) begin
                    mActive[i]  = 1'b0;
                    mK[i]       = 0;
                    mRow[i]     = 0;
                    mCol[i]     = 0;
                    mContact[i] = 1'b0;
                end
                expQ.delete();
                p.e0 = RESET_EXP;
                p.e1 = RESET_EXP;
                expQ.push_back(p);
            end else begin
                for (int i = 0; i < 2; i++) begin
                    b   = (i == 0) ? B0 : B1;
                    per = (i == 0) ? P0 : P1;
                    e.column = 4'b1111;
                    if (mContact[i] && rowIn[3 - mRow[i]] == 1'b0) e.column = colBits(mCol[i]);
                    e.done = 1'b0;
                    e.err  = 1'b0;
                    if (mActive[i]) begin
                        mK[i] = mK[i] + 1;
                        if (mK[i] == 2*b + HOLD + GAP) begin
                            mActive[i] = 1'b0;
                            e.done     = 1'b1;
                        end
                    end else if (keyValid) begin
                        idx = keyIndex(keyChar);
                        if (idx < 0) begin
                            e.err = 1'b1;
                        end else begin
                            mActive[i] = 1'b1;
                            mK[i]      = 0;
                            mRow[i]    = idx / 4;
                            mCol[i]    = idx % 4;
                        end
                    end
                    mContact[i] = mActive[i] ? contactAt(mK[i], b, per) : 1'b0;
                    e.ready = !mActive[i];
                    e.busy  = mActive[i];
                    if (i == 0) p.e0 = e;
                    else        p.e1 = e;
                end
                expQ.push_back(p);
            end
        end
    end

    task automatic checkOutput(input int inst, input exp_t act, input exp_t expv);
        compared++;
        if (act !== expv) begin
            mismatched++;
            $display("[TB] FAIL outputs inst%0d cycle %0d: got col=%b rdy=%b busy=%b done=%b err=%b, want col=%b rdy=%b busy=%b done=%b err=%b",
                     inst, cycleNum, act.column, act.ready, act.busy, act.done, act.err,
                     expv.column, expv.ready, expv.busy, expv.done, expv.err);
        end
    endtask

    // Monitor: pop one expectation per cycle and compare on the falling edge
    initial begin : monitor
        exp_pair_t p;
        exp_t      a;
        forever begin
            @(negedge clk);
            cycleNum++;
            if (expQ.size() > 0) begin
                p = expQ.pop_front();
                a = '{column: column0, ready: ready0, busy: busy0, done: done0, err: err0};
                checkOutput(0, a, p.e0);
                a = '{column: column1, ready: ready1, busy: busy1, done: done1, err: err1};
                checkOutput(1, a, p.e1);
            end
        end
    end

    task automatic driveCycle(input logic [7:0] ch, input logic v, input logic [3:0] r);
        @(posedge clk);
        #1;
        keyChar  = ch;
        keyValid = v;
        rowIn    = r;
    endtask

    // One request strobe followed by idle cycles with the row held
    task automatic applyStimulus(input logic [7:0] ch, input logic [3:0] r, input int idleCycles);
        driveCycle(ch, 1'b1, r);
        repeat (idleCycles) driveCycle(ch, 1'b0, r);
    endtask

    task automatic doReset(input int cycles);
        @(posedge clk);
        #2;
        rst = 1'b1;
        repeat (cycles) @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    initial begin : stimulus
        logic [3:0] rowPats [4];
        string      mapStr;
        string      badStr;
        int         sel;
        logic [7:0] ch;
        logic [3:0] r;

        rowPats    = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
        mapStr     = "123A456B789C*0#D";
        badStr     = "Za!E";
        compared   = 0;
        mismatched = 0;
        cycleNum   = 0;
        rst        = 1'b1;
        keyChar    = 8'h00;
        keyValid   = 1'b0;
        rowIn      = 4'b1111;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;

        $display("[TB] directed: '5' with row 1 driven, then row 0");
        driveCycle(8'h35, 1'b1, 4'b1011);
        repeat (14) driveCycle(8'h35, 1'b0, 4'b1011);
        repeat (3)  driveCycle(8'h35, 1'b0, 4'b0111);
        repeat (35) driveCycle(8'h35, 1'b0, 4'b1011);

        $display("[TB] directed: '#' on row 3, 'A' on row 0");
        applyStimulus(8'h23, 4'b1110, 50);
        applyStimulus(8'h41, 4'b0111, 50);

        $display("[TB] directed: unmapped chars");
        applyStimulus(8'h5A, 4'b0111, 3);
        applyStimulus(8'h61, 4'b1111, 3);

        $display("[TB] directed: second request during HOLD is ignored");
        applyStimulus(8'h31, 4'b0111, 12);
        repeat (5) driveCycle(8'h32, 1'b1, 4'b0111);
        repeat (45) driveCycle(8'h32, 1'b0, 4'b0111);

        $display("[TB] directed: '0' on row 3, multi-row and idle rows");
        applyStimulus(8'h30, 4'b1110, 20);
        repeat (5)  driveCycle(8'h30, 1'b0, 4'b0110);
        repeat (5)  driveCycle(8'h30, 1'b0, 4'b1111);
        repeat (25) driveCycle(8'h30, 1'b0, 4'b1110);

        $display("[TB] directed: reset during HOLD");
        applyStimulus(8'h31, 4'b0111, 15);
        doReset(2);
        applyStimulus(8'h44, 4'b1110, 50);

        $display("[TB] random phase");
        for (int n = 0; n < 2500; n++) begin
            sel = $urandom_range(0, 19);
            if (sel < 16) ch = mapStr[sel];
            else          ch = badStr[sel - 16];
            case ($urandom_range(0, 5))
                0, 1, 2, 3: r = rowPats[$urandom_range(0, 3)];
                4:          r = 4'b1111;
                default:    r = 4'($urandom);
            endcase
            driveCycle(ch, ($urandom_range(0, 9) == 0), r);
            if ($urandom_range(0, 599) == 0) doReset($urandom_range(1, 3));
        end

        driveCycle(8'h00, 1'b0, 4'b1111);
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/keypad_emulador.md
Name: keypad_emulador

Overview:
Responder end of the 4x4 matrix-keypad interface. It accepts an ASCII key request over a valid/ready handshake, then behaves like the physical keypad: it watches the row lines driven by the keypad scanner and pulls the matching column line low while the key is "pressed". Optional contact bounce is modelled at press and release. It is used for hardware-in-loop and closed-loop verification of the scanner, and as a virtual keypad behind a UART.

Parameters:
HOLD_CYCLES, 2000000, clean-press duration in clk cycles (40 ms at 50 MHz); must be >= 1.
GAP_CYCLES, 1500000, released time after a key before the next request is accepted; must be >= 1.
BOUNCE_CYCLES, 50000, bounce window at press and at release; 0 disables bounce.
BOUNCE_PERIOD, 5000, contact toggles every BOUNCE_PERIOD cycles inside a bounce window; must be >= 1.

Ports:
clk  input  1  system clock
rst  input  1  reset; asynchronous, active-high
key_char  input  8  ASCII code of the key to press
key_valid  input  1  request strobe
key_ready  output  1  high when a request can be accepted
row  input  4  row drive from the scanner, active-low; 4'b0111 = row 0
column  output  4  column lines to the scanner, active-low, idle 4'b1111; 4'b0111 = column 0
busy  output  1  high from acceptance until the end of GAP
done  output  1  1-cycle pulse when GAP ends
key_error  output  1  1-cycle pulse when an unmapped char is offered

Behaviour:
- Reset is asynchronous, active-high, on clock clk. Reset values: column=4'b1111, key_ready=1, busy=0, done=0, key_error=0, state=IDLE, counters=0, contact=0.
- Key map (row, col): row0 = '1','2','3','A' (31,32,33,41h); row1 = '4','5','6','B'; row2 = '7','8','9','C'; row3 = '*'(2Ah), '0'(30h), '#'(23h), 'D'. Row index r maps to row bit (3-r). Column index c maps to column bit (3-c).
- Any other char, including lowercase, is unmapped.
- A request is accepted when key_valid && key_ready. The char is latched and decoded that cycle. key_valid while key_ready=0 is ignored, with no queueing.
- Unmapped char in IDLE: key_error=1 on the next cycle for one cycle. State stays IDLE, key_ready stays 1, column stays 4'b1111.
- State machine:
  - IDLE (key_ready=1): on a mapped request, go to BOUNCE_IN, or to HOLD if BOUNCE_CYCLES=0.
  - BOUNCE_IN (BOUNCE_CYCLES cycles): contact starts at 1 and inverts every BOUNCE_PERIOD cycles. Then go to HOLD.
  - HOLD (HOLD_CYCLES cycles): contact=1. Then go to BOUNCE_OUT, or to GAP if bounce is disabled.
  - BOUNCE_OUT (BOUNCE_CYCLES cycles): contact starts at 0 and inverts every BOUNCE_PERIOD cycles. Then go to GAP.
  - GAP (GAP_CYCLES cycles): contact=0. On the last cycle, done=1 for one cycle; next state is IDLE.
- key_ready is 1 only in IDLE. busy is 1 in every non-IDLE state.
- Column output is registered, 1-cycle latency from row:
  - column <= 4'b1111 with bit (3-c) cleared iff contact=1 and row bit (3-r)=0.
  - Otherwise column <= 4'b1111.
- Multiple row bits low: only the latched key's row matters. row=4'b1111 always yields column=4'b1111.
- Each counter is $clog2(max parameter + 1) bits wide. It clears on every state entry and compares against (param-1). There is no wrap-around inside a state.
- Reset mid-operation: column returns to 4'b1111 immediately (async) and the latched key is discarded.

Decomposition:
- Package keypad_pkg:
  - ASCII key constants.
  - ROW_PATTERN/COL_PATTERN localparams (4'b0111, 4'b1011, 4'b1101, 4'b1110).
  - State encoding (IDLE, BOUNCE_IN, HOLD, BOUNCE_OUT, GAP).
  - This package is shared with the scanner.
- Sub-module keypad_ascii_decode (combinational): key_char -> {mapped, row_idx[1:0], col_idx[1:0]}. The FSM, counters and column register stay in keypad_emulador.

Test Plan:
All tests use HOLD=20, GAP=10, BOUNCE=0, PERIOD=1 unless stated.
- Send '5' (35h); hold row=4'b1011 -> busy=1 next cycle; column=4'b1011 one cycle after HOLD entry; row=4'b0111 -> column=4'b1111 next cycle; done pulses 30 cycles after acceptance.
- Send '#' (23h), row=4'b1110 -> column=4'b1101. Send 'A' (41h), row=4'b0111 -> column=4'b1110.
- Send 'Z' (5Ah) -> key_error=1 for exactly one cycle; column stays 4'b1111; key_ready stays 1.
- Send '1', then assert key_valid with '2' during HOLD -> '2' ignored; only column 4'b0111 activity; key_ready returns at IDLE.
- BOUNCE=8, PERIOD=2, send '0', row=4'b1110 -> column alternates 4'b1011/4'b1111 every 2 cycles for 8 cycles, steady 4'b1011 for 20, then bounces for 8 before release.
- Assert rst during HOLD with column=4'b0111 -> column=4'b1111 within the same cycle; key_ready=1, busy=0 after reset.
- Closed loop with the keypad scanner at small scan params, sending '7' -> scanner reports 37h with a single key_detected pulse.
